// File: rtl/mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single shared MAC
//            engine. The granted requester streams operand beats into the MAC.
//            The arbiter then issues a read pulse, waits RES_LAT cycles and
//            returns the result (plus a sticky burst error) on the requester's
//            response channel.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            rqN_valid/ready/a/b/mode/last - operand beat channel, N = 0,1
//            rsN_valid/ready/data/err      - result channel, N = 0,1
//            mac_a/b/en/vld/rd/mode/cfg    - registered MAC control/data out
//            mac_c, mac_error              - MAC result inputs
//            busy                          - arbiter is not idle
//            grant                         - current (or last) owner index
// Revision : 1.0 - initial release
// ============================================================================
module mac_arbiter #(
  parameter int RES_LAT   = 2,
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [15:0] rq0_a,
  input  logic [15:0] rq0_b,
  input  logic        rq0_mode,
  input  logic        rq0_last,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [15:0] rq1_a,
  input  logic [15:0] rq1_b,
  input  logic        rq1_mode,
  input  logic        rq1_last,
  output logic        rs0_valid,
  input  logic        rs0_ready,
  output logic [15:0] rs0_data,
  output logic        rs0_err,
  output logic        rs1_valid,
  input  logic        rs1_ready,
  output logic [15:0] rs1_data,
  output logic        rs1_err,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_en,
  output logic        mac_vld,
  output logic        mac_rd,
  output logic        mac_mode,
  output logic        mac_cfg,
  input  logic [15:0] mac_c,
  input  logic        mac_error,
  output logic        busy,
  output logic        grant
);

  localparam int              c_BW        = $clog2(MAX_BURST);
  localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(MAX_BURST - 1);
  localparam logic [c_BW-1:0] c_BEAT_ONE  = c_BW'(1);
  localparam logic [3:0]      c_LAT       = 4'(RES_LAT);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CFG    = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_READ   = 3'd3;
  localparam logic [2:0] c_WAIT   = 3'd4;
  localparam logic [2:0] c_RESP   = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_next;

  logic            r_grant;
  logic            r_prio;       // requester favoured on the next tie
  logic            r_err;        // sticky burst error
  logic [c_BW-1:0] r_beat;
  logic [3:0]      r_lat;

  logic            r_rq0_ready, r_rq1_ready;
  logic            r_mac_cfg, r_mac_en, r_mac_rd, r_mac_vld, r_mac_mode;
  logic [15:0]     r_mac_a, r_mac_b;
  logic            r_rs0_valid, r_rs1_valid;
  logic [15:0]     r_rs0_data, r_rs1_data;
  logic            r_rs0_err, r_rs1_err;

  logic            w_rq0_ready_d, w_rq1_ready_d;
  logic            w_mac_cfg_d, w_mac_en_d, w_mac_rd_d;
  logic            w_rs0_valid_d, w_rs1_valid_d;

  logic            w_req_any, w_gnt_sel;
  logic            w_g_valid, w_g_ready, w_g_mode, w_g_last, w_rs_ready;
  logic [15:0]     w_g_a, w_g_b;
  logic            w_accept, w_cap_full, w_burst_end, w_sample, w_resp_done;

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  assign w_req_any = rq0_valid | rq1_valid;
  assign w_gnt_sel = (rq0_valid & rq1_valid) ? r_prio : rq1_valid;

  // Granted-requester views
  assign w_g_valid  = r_grant ? rq1_valid   : rq0_valid;
  assign w_g_ready  = r_grant ? r_rq1_ready : r_rq0_ready;
  assign w_g_mode   = r_grant ? rq1_mode    : rq0_mode;
  assign w_g_last   = r_grant ? rq1_last    : rq0_last;
  assign w_g_a      = r_grant ? rq1_a       : rq0_a;
  assign w_g_b      = r_grant ? rq1_b       : rq0_b;
  assign w_rs_ready = r_grant ? rs1_ready   : rs0_ready;

  // Ready is only ever registered high in STREAM, so this is the handshake.
  assign w_accept    = w_g_valid & w_g_ready;
  // The MAX_BURST-th beat closes the burst even without last.
  assign w_cap_full  = (r_beat == c_BEAT_LAST);
  assign w_burst_end = w_accept & (w_g_last | w_cap_full);
  assign w_sample    = (r_state == c_WAIT) & (r_lat == c_LAT);
  assign w_resp_done = (r_state == c_RESP) & w_rs_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (w_req_any)   w_next = c_CFG;
      c_CFG:                     w_next = c_STREAM;
      c_STREAM: if (w_burst_end) w_next = c_READ;
      c_READ:                    w_next = c_WAIT;
      c_WAIT:   if (w_sample)    w_next = c_RESP;
      c_RESP:   if (w_resp_done) w_next = c_IDLE;
      default:                   w_next = c_IDLE;
    endcase
  end

  // FSM: output logic. Control outputs are registered from the next state so
  // they line up with the state they describe.
  always_comb begin
    w_rq0_ready_d = (w_next == c_STREAM) & ~r_grant;
    w_rq1_ready_d = (w_next == c_STREAM) &  r_grant;
    w_mac_cfg_d   = (w_next == c_CFG);
    // Held through the WAIT cycle that samples the result.
    w_mac_en_d    = (w_next == c_STREAM) | (w_next == c_READ) | (w_next == c_WAIT);
    w_mac_rd_d    = (r_state == c_READ);
    w_rs0_valid_d = (w_next == c_RESP) & ~r_grant;
    w_rs1_valid_d = (w_next == c_RESP) &  r_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq0_ready <= 1'b0;
      r_rq1_ready <= 1'b0;
      r_mac_cfg   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_mac_rd    <= 1'b0;
      r_rs0_valid <= 1'b0;
      r_rs1_valid <= 1'b0;
    end else begin
      r_rq0_ready <= w_rq0_ready_d;
      r_rq1_ready <= w_rq1_ready_d;
      r_mac_cfg   <= w_mac_cfg_d;
      r_mac_en    <= w_mac_en_d;
      r_mac_rd    <= w_mac_rd_d;
      r_rs0_valid <= w_rs0_valid_d;
      r_rs1_valid <= w_rs1_valid_d;
    end
  end

  // Datapath, grant bookkeeping, counters and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= 1'b0;
      r_prio     <= 1'b0;
      r_mac_mode <= 1'b0;
      r_mac_a    <= 16'd0;
      r_mac_b    <= 16'd0;
      r_mac_vld  <= 1'b0;
      r_beat     <= '0;
      r_lat      <= 4'd0;
      r_err      <= 1'b0;
      r_rs0_data <= 16'd0;
      r_rs0_err  <= 1'b0;
      r_rs1_data <= 16'd0;
      r_rs1_err  <= 1'b0;
    end else begin
      r_mac_vld <= w_accept;

      if ((r_state == c_IDLE) && w_req_any) begin
        r_grant    <= w_gnt_sel;
        r_prio     <= ~w_gnt_sel;
        r_mac_mode <= w_gnt_sel ? rq1_mode : rq0_mode;
        r_err      <= 1'b0;
        r_beat     <= '0;
      end

      if (w_accept) begin
        r_mac_a <= w_g_a;
        r_mac_b <= w_g_b;
        // Mode mismatches are still issued; they only taint the response.
        if ((w_g_mode != r_mac_mode) || (w_cap_full && !w_g_last))
          r_err <= 1'b1;
        r_beat <= w_burst_end ? '0 : (r_beat + c_BEAT_ONE);
      end

      if (r_state == c_READ)
        r_lat <= 4'd0;
      else if ((r_state == c_WAIT) && !w_sample)
        r_lat <= r_lat + 4'd1;

      if (w_sample) begin
        if (r_grant) begin
          r_rs1_data <= mac_c;
          r_rs1_err  <= mac_error | r_err;
        end else begin
          r_rs0_data <= mac_c;
          r_rs0_err  <= mac_error | r_err;
        end
      end
    end
  end

  assign rq0_ready = r_rq0_ready;
  assign rq1_ready = r_rq1_ready;
  assign rs0_valid = r_rs0_valid;
  assign rs1_valid = r_rs1_valid;
  assign rs0_data  = r_rs0_data;
  assign rs1_data  = r_rs1_data;
  assign rs0_err   = r_rs0_err;
  assign rs1_err   = r_rs1_err;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_en    = r_mac_en;
  assign mac_vld   = r_mac_vld;
  assign mac_rd    = r_mac_rd;
  assign mac_mode  = r_mac_mode;
  assign mac_cfg   = r_mac_cfg;
  assign busy      = (r_state != c_IDLE);
  assign grant     = r_grant;

endmodule
`default_nettype wire

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 SHALL have parameter RES_LAT, default 2: cycles from mac_rd pulse to valid mac_c/mac_error (range 1..15).
REQ-002 SHALL have parameter MAX_BURST, default 64: maximum operand beats per burst (range 2..1024).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rq0_valid/rq1_valid  in  1  requester operand beat valid.
REQ-006 SHALL have ports rq0_ready/rq1_ready  out  1  operand beat accepted.
REQ-007 SHALL have ports rq0_a, rq0_b, rq1_a, rq1_b  in  16  operands.
REQ-008 SHALL have ports rq0_mode/rq1_mode  in  1  0=INT, 1=FP.
REQ-009 SHALL have ports rq0_last/rq1_last  in  1  final beat of burst.
REQ-010 SHALL have ports rs0_valid/rs1_valid  out  1  result valid; rs0_ready/rs1_ready  in  1.
REQ-011 SHALL have ports rs0_data/rs1_data  out  16 and rs0_err/rs1_err  out  1.
REQ-012 SHALL have ports mac_a, mac_b  out  16; mac_en, mac_vld, mac_rd, mac_mode, mac_cfg  out  1.
REQ-013 SHALL have ports mac_c  in  16 and mac_error  in  1.
REQ-014 SHALL have ports busy  out  1 (state != IDLE) and grant  out  1 (current/last owner index).

Function
REQ-015 SHALL drive every MAC-side and rs-side output from a register.
REQ-016 SHALL implement FSM states IDLE, CFG, STREAM, READ, WAIT, RESP.
REQ-017 IDLE: if exactly one rqN_valid, grant N; if both, grant the requester not granted last; go to CFG.
REQ-018 CFG (1 cycle): latch granted rqN_mode into mac_mode; assert mac_cfg for exactly one cycle; no beat accepted; go to STREAM.
REQ-019 SHALL assert mac_en from the first STREAM cycle through the WAIT cycle in which the result is sampled.
REQ-020 STREAM: rqG_ready=1 for granted requester only; non-granted rq_ready=0 at all times.
REQ-021 An accepted beat (valid&ready) at cycle t SHALL appear on mac_a/mac_b with mac_vld=1 at cycle t+1; mac_vld=0 otherwise.
REQ-022 A beat whose mode differs from the latched mode SHALL still be issued and SHALL set the sticky burst error flag.
REQ-023 Beat counter: when a beat is the MAX_BURST-th without last, it SHALL be treated as last and set the error flag.
REQ-024 After last beat accepted at t: STREAM->READ; mac_rd one-cycle pulse at t+2 (after final mac_vld).
REQ-025 WAIT: SHALL count RES_LAT cycles after mac_rd and sample mac_c, mac_error at cycle rd+RES_LAT.
REQ-026 RESP: rsG_data=sampled mac_c, rsG_err=mac_error|error flag, rsG_valid held until rsG_ready; then IDLE with rsG_valid=0 next cycle.
REQ-027 New requests during non-IDLE states SHALL be stalled (ready=0), never dropped.
REQ-028 Round-robin pointer SHALL update only on grant; a single requester may be granted back-to-back.

Reset
REQ-029 On rst_n low: state IDLE, all outputs 0, counters 0, error flag 0, grant=0, pointer favours rq0 on next tie.
REQ-030 Reset asserted mid-burst or mid-WAIT SHALL abandon the transaction; no rs_valid is ever produced for it.

Verification
REQ-031 rq0 sends 3 beats (a=1,b=2),(3,4),(5,6) INT, mac model returns c=0x002C after RES_LAT=2 -> one mac_cfg pulse, 3 mac_vld cycles, mac_rd 2 cycles after last accept, rs0_data=0x002C, rs0_err=0.
REQ-032 rq0 and rq1 valid same cycle after reset -> grant=0 first; rs0 response, then rq1 granted; repeat tie -> rq0 again after rq1.
REQ-033 rq1 burst with mode=1 first beat, mode=0 second beat -> both beats issued, rs1_err=1.
REQ-034 MAX_BURST=4, rq0 sends 6 beats without last -> 4th beat forces READ, rs0_err=1, remaining beats start new burst.
REQ-035 rs0_ready held low 5 cycles -> rs0_valid and rs0_data stable, rq1 stalled with rq1_ready=0 until handoff.
REQ-036 rst_n pulsed low during WAIT -> all outputs 0 immediately, no rs_valid afterwards, next request starts cleanly at CFG.
